alu_scheduler: RTL and testbench
================================

# alu_scheduler

Time-shares a single combinational `alu` instance between `N_REQ` requesters using round-robin arbitration and per-requester valid/ready handshakes. It registers the granted request's operands and evaluates them in one dedicated cycle. It then holds the registered result on a response channel until the owning requester accepts it. The block sits between the instruction-issue logic (or multiple functional clients) and the `alu` datapath.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be at least 2.
- `ID_W`, `$clog2(N_REQ)`: width of the requester index.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester request accept; one-hot or zero.
- `req_a`  in  N_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- `req_b`  in  N_REQ*32  operand B, same packing as `req_a`.
- `req_op`  in  N_REQ*4  ALU opcode; requester i occupies bits [4i+3:4i].
- `resp_valid`  out  N_REQ  response valid to the owning requester; one-hot or zero.
- `resp_ready`  in  N_REQ  per-requester response accept.
- `resp_result`  out  32  registered ALU result.
- `resp_zero`  out  1  registered ALU zero flag.
- `resp_err`  out  1  opcode was outside the legal range 0–9.
- `resp_id`  out  ID_W  index of the response owner.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Three-state FSM: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitration is round-robin. Priority starts at `(last_grant+1) mod N_REQ` and searches upward with wrap-around.
  - After reset, `last_grant = N_REQ-1`, so requester 0 has the highest priority.
  - `req_ready[g]` is combinational and equals one only for the winner `g`, and only in IDLE.
  - On `req_valid[g] && req_ready[g]`:
    - latch `a`, `b`, `op` and `g`;
    - set `last_grant = g`;
    - go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE and leave the pointer unchanged.
- **EXEC**
  - The ALU sees only the latched operands and opcode.
  - At the end of the cycle, capture `result`, `zero` and `err = (op > 4'd9)`.
  - Go to RESP.
- **RESP**
  - `resp_valid[id] = 1`. The result, zero, error and id outputs hold stable.
  - On `resp_ready[id]`, return to IDLE.
  - `resp_ready` bits of non-owners are ignored.
  - Requests are not accepted in EXEC or RESP: `req_ready` is all zero.
- **Illegal opcodes** (4'hA–4'hF): the ALU returns 0, so `resp_result = 0`, `resp_zero = 1`, `resp_err = 1`. The FSM flow is unchanged.
- **Requester behaviour:** a requester must hold `req_*` stable while `req_valid` is high and not yet accepted. The scheduler never drops a request it has accepted.
- **Reset values:**
  - state IDLE;
  - `req_ready = 0`, `resp_valid = 0`;
  - `resp_result = 0`, `resp_zero = 0`, `resp_err = 0`, `resp_id = 0`;
  - `busy = 0`.
- **Reset mid-operation:** reset in EXEC or RESP aborts the operation immediately and discards the result. No response is issued after reset.

## Timing
- Accept at edge T (end of IDLE cycle) → EXEC during cycle T+1 → `resp_valid` high from cycle T+2.
- Minimum response latency is 2 cycles from acceptance.
- Minimum issue interval is 3 cycles per operation (IDLE, EXEC, RESP) when `resp_ready` is already high.
- `resp_ready` held low stalls the block in RESP indefinitely. All response outputs stay stable throughout the stall.
- Simultaneous requests:
  - exactly one is granted per IDLE cycle;
  - losers keep `req_valid` high and win on later passes in rotating order;
  - no requester waits more than `N_REQ-1` grants.
- `resp_valid` deasserts in the cycle after the accepting edge.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_OP_W = 4`;
  - opcode constants: `ALU_ADD = 0`, `ALU_SUB = 1`, `ALU_MUL = 2`, `ALU_SHL = 3`, `ALU_SHR = 4`, `ALU_FMUL = 5`, `ALU_FLOOR = 6`, `ALU_FLOOR_INT = 7`, `ALU_FCMP = 8`, `ALU_ICMP = 9`;
  - `ALU_OP_LAST = 9`;
  - the FSM state enum.
- Sub-modules:
  - `rr_arbiter` (parameter `N`): inputs `req` and `last_grant`, outputs a one-hot `grant` and `grant_id`. It is purely combinational.
  - One `alu` instance.

## Test plan
- **Single add:** requester 1 sends a=5, b=7, op 0 with `resp_ready` held high.
  - `resp_valid = 4'b0010` two cycles after acceptance.
  - `resp_result = 12`, `resp_zero = 0`, `resp_id = 1`.
- **Contention:** after reset, requesters 0 and 2 both stay valid (op 1, a=9, b=9).
  - Grant order is 0, then 2, then 0.
  - `resp_result = 0`, `resp_zero = 1` on each response.
  - All four requesters valid → grants rotate 0, 1, 2, 3, 0.
- **Backpressure:** hold `resp_ready` low for 5 cycles on an op-2 request with 6×7.
  - `resp_result` holds at 42 and `busy = 1` throughout.
  - `req_ready` stays 0 while requester 3 is valid.
  - Release → return to IDLE → requester 3 is granted on the next cycle.
- **Float multiply:** op 5, a=32'h40000000, b=32'h40400000 → `resp_result = 32'h40C00000`.
- **Illegal opcode:** op 4'hC → `resp_result = 0`, `resp_zero = 1`, `resp_err = 1`. The next legal op has `resp_err = 0`.
- **Reset mid-operation:** assert `rst` during RESP.
  - `resp_valid` drops to 0 asynchronously and `busy = 0`.
  - The next grant goes to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, widths and scheduler state encoding
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD       = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB       = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_MUL       = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SHL       = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SHR       = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_FMUL      = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_FLOOR     = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_FLOOR_INT = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_FCMP      = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_ICMP      = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_LAST   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer / single-precision ALU; illegal opcodes yield zero
module alu
    import alu_pkg::*;
(
    input  logic [31:0]         a_i,
    input  logic [31:0]         b_i,
    input  logic [ALU_OP_W-1:0] op_i,
    output logic [31:0]         result_o,
    output logic                zero_o
);

    // Float multiply, truncating; denormal inputs and underflow flush to signed zero.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        s = x[31] ^ y[31];
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 10'd1;
        end else begin
            m = p[45:23];
        end
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || e[9] || e == 10'd0)
            fmul = {s, 31'd0};
        else if (e >= 10'd255)
            fmul = {s, 8'hFF, 23'd0};
        else
            fmul = {s, e[7:0], m};
    endfunction

    // Float floor returned as a float: drop fraction bits, rounding negatives downward.
    function automatic logic [31:0] ffloor(input logic [31:0] x);
        logic [7:0]  e;
        logic [30:0] mask;
        e    = x[30:23];
        mask = 31'h007F_FFFF >> (e - 8'd127);
        if (e >= 8'd150)
            ffloor = x;
        else if (e < 8'd127)
            ffloor = (x[31] && x[30:0] != 31'd0) ? 32'hBF80_0000 : {x[31], 31'd0};
        else if (x[31] && (x[30:0] & mask) != 31'd0)
            ffloor = {1'b1, (x[30:0] & ~mask) + mask + 31'd1};
        else
            ffloor = {x[31], x[30:0] & ~mask};
    endfunction

    // Float floor returned as a saturating signed 32-bit integer.
    function automatic logic [31:0] ffloor_int(input logic [31:0] x);
        logic [7:0]  e;
        logic [23:0] m;
        logic [31:0] mag;
        logic        frac;
        e    = x[30:23];
        m    = {1'b1, x[22:0]};
        mag  = 32'd0;
        frac = 1'b0;
        if (e < 8'd127) begin
            ffloor_int = (x[31] && x[30:0] != 31'd0) ? 32'hFFFF_FFFF : 32'd0;
        end else if (e >= 8'd158) begin
            ffloor_int = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            if (e >= 8'd150) begin
                mag = {8'd0, m} << (e - 8'd150);
            end else begin
                mag  = {8'd0, m} >> (8'd150 - e);
                frac = (m & (24'hFF_FFFF >> (e - 8'd126))) != 24'd0;
            end
            ffloor_int = x[31] ? -(mag + {31'd0, frac}) : mag;
        end
    endfunction

    // Total order on floats via sign-magnitude to unsigned key; +0 and -0 compare equal.
    function automatic logic [31:0] fcmp(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] kx;
        logic [31:0] ky;
        kx = x[31] ? ~x : {1'b1, x[30:0]};
        ky = y[31] ? ~y : {1'b1, y[30:0]};
        if (x[30:0] == 31'd0 && y[30:0] == 31'd0) fcmp = 32'd0;
        else if (kx < ky)                         fcmp = 32'd1;
        else if (kx > ky)                         fcmp = 32'd2;
        else                                      fcmp = 32'd0;
    endfunction

    // Opcode decode; comparisons return 0 equal, 1 less-than, 2 greater-than.
    always_comb begin
        result_o = 32'd0;
        case (op_i)
            ALU_ADD:       result_o = a_i + b_i;
            ALU_SUB:       result_o = a_i - b_i;
            ALU_MUL:       result_o = a_i * b_i;
            ALU_SHL:       result_o = a_i << b_i[4:0];
            ALU_SHR:       result_o = a_i >> b_i[4:0];
            ALU_FMUL:      result_o = fmul(a_i, b_i);
            ALU_FLOOR:     result_o = ffloor(a_i);
            ALU_FLOOR_INT: result_o = ffloor_int(a_i);
            ALU_FCMP:      result_o = fcmp(a_i, b_i);
            ALU_ICMP:      result_o = ($signed(a_i) < $signed(b_i)) ? 32'd1 :
                                      ($signed(a_i) > $signed(b_i)) ? 32'd2 : 32'd0;
            default:       result_o = 32'd0;
        endcase
        zero_o = (result_o == 32'd0);
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting after the last winner
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id
);

    int   idx;
    logic found;

    // Search upward with wrap-around from last_grant+1; the first active requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx[$clog2(N)-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin time-sharing of one ALU between N_REQ requesters
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*32-1:0]       req_a,
    input  logic [N_REQ*32-1:0]       req_b,
    input  logic [N_REQ*ALU_OP_W-1:0] req_op,
    output logic [N_REQ-1:0]          resp_valid,
    input  logic [N_REQ-1:0]          resp_ready,
    output logic [31:0]               resp_result,
    output logic                      resp_zero,
    output logic                      resp_err,
    output logic [ID_W-1:0]           resp_id,
    output logic                      busy
);

    sched_state_e          state_q;
    logic [31:0]           a_q;
    logic [31:0]           b_q;
    logic [ALU_OP_W-1:0]   op_q;
    logic [ID_W-1:0]       id_q;
    logic [ID_W-1:0]       last_grant_q;
    logic [31:0]           result_q;
    logic                  zero_q;
    logic                  err_q;
    logic [N_REQ-1:0]      resp_valid_q;

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_id;
    logic                  accept;
    logic [31:0]           alu_result;
    logic                  alu_zero;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Only the arbitration winner sees ready, and only while idle and out of reset.
    always_comb begin
        req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
        accept    = |(req_valid & req_ready);
    end

    // Scheduler FSM: accept one request in IDLE, evaluate it in EXEC, hold the response in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q          <= req_a[32*grant_id +: 32];
                        b_q          <= req_b[32*grant_id +: 32];
                        op_q         <= req_op[ALU_OP_W*grant_id +: ALU_OP_W];
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q     <= alu_result;
                    zero_q       <= alu_zero;
                    err_q        <= (op_q > ALU_OP_LAST);
                    resp_valid_q <= N_REQ'(1) << id_q;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready[id_q]) begin
                        resp_valid_q <= '0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp_err    = err_q;
    assign resp_id     = id_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - self-checking bench for alu_scheduler
module tb_alu_scheduler;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*4-1:0]  req_op;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [31:0]     resp_result;
    logic            resp_zero;
    logic            resp_err;
    logic [IW-1:0]   resp_id;
    logic            busy;

    int checks = 0;
    int passed = 0;
    int last_model;

    logic [31:0] pa [N];
    logic [31:0] pb [N];
    logic [3:0]  pop[N];

    logic [31:0] fl_a  [6] = '{32'h4000_0000, 32'hC020_0000, 32'hC020_0000, 32'h3F80_0000, 32'h4020_0000, 32'h0000_0000};
    logic [31:0] fl_b  [6] = '{32'h4040_0000, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'h4040_0000};
    logic [3:0]  fl_op [6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd6, 4'd5};
    logic [31:0] fl_exp[6] = '{32'h40C0_0000, 32'hC040_0000, 32'hFFFF_FFFD, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000};

    always #5 clk = ~clk;

    alu_scheduler #(.N_REQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .resp_id     (resp_id),
        .busy        (busy)
    );

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int d = 1; d <= N; d++)
            if (mask[(last + d) % N]) return (last + d) % N;
        return -1;
    endfunction

    function automatic logic [31:0] ref_int(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a << (b % 32);
            4'd4:    return a >> (b % 32);
            4'd9:    return (sa < sb) ? 32'd1 : (sa > sb) ? 32'd2 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        int o;
        o = $urandom_range(0, 15);
        if (o >= 5 && o <= 8) o = o - 5;
        return 4'(o);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = pa[i];
            req_b[32*i +: 32] = pb[i];
            req_op[4*i +: 4]  = pop[i];
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '1;
        for (int i = 0; i < N; i++) begin
            pa[i] = 32'd0; pb[i] = 32'd0; pop[i] = 4'd0;
        end
        apply();
        tick();
        tick();
        rst        = 1'b0;
        last_model = N - 1;
    endtask

    // Waits for a grant, then for the response, and accepts it (resp_ready assumed high).
    task automatic capture_op(output int g, output int rid, output logic [N-1:0] rv,
                              output logic [31:0] res, output logic z, output logic e, output bit to);
        int n;
        g = -1; rid = -1; rv = '0; res = '0; z = 1'b0; e = 1'b0; to = 1'b0;
        #1;
        n = 0;
        while ((req_ready & req_valid) == '0 && n < 50) begin tick(); n++; end
        if ((req_ready & req_valid) == '0) begin to = 1'b1; return; end
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        tick();
        n = 0;
        while (resp_valid == '0 && n < 50) begin tick(); n++; end
        if (resp_valid == '0) begin to = 1'b1; return; end
        rid = int'(resp_id); rv = resp_valid; res = resp_result; z = resp_zero; e = resp_err;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        resp_ready = '1;
        for (int i = 0; i < N; i++) begin pa[i] = 32'd1; pb[i] = 32'd2; pop[i] = 4'd0; end
        apply();
        tick();
        checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b expected 0", req_ready); else passed++;
        checks++; if (resp_valid !== '0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else passed++;
        checks++; if (resp_result !== 32'd0) $display("FAIL reset_result: got %h expected 0", resp_result); else passed++;
        checks++; if (resp_zero !== 1'b0 || resp_err !== 1'b0) $display("FAIL reset_flags: got zero=%b err=%b expected 0 0", resp_zero, resp_err); else passed++;
        checks++; if (resp_id !== '0) $display("FAIL reset_id: got %0d expected 0", resp_id); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        do_reset();
        pa[1] = 32'd5; pb[1] = 32'd7; pop[1] = 4'd0;
        apply();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL add_req_ready: got %b expected 0010", req_ready); else passed++;
        tick();
        req_valid = '0;
        checks++; if (busy !== 1'b1 || resp_valid !== '0) $display("FAIL add_exec: got busy=%b resp_valid=%b expected 1 0000", busy, resp_valid); else passed++;
        checks++; if (req_ready !== '0) $display("FAIL add_exec_ready: got %b expected 0", req_ready); else passed++;
        tick();
        checks++; if (resp_valid !== 4'b0010) $display("FAIL add_resp_valid: got %b expected 0010", resp_valid); else passed++;
        checks++; if (resp_result !== 32'd12 || resp_zero !== 1'b0 || resp_err !== 1'b0) $display("FAIL add_result: got %0d z=%b e=%b expected 12 0 0", resp_result, resp_zero, resp_err); else passed++;
        checks++; if (resp_id !== 2'd1) $display("FAIL add_id: got %0d expected 1", resp_id); else passed++;
        tick();
        checks++; if (resp_valid !== '0 || busy !== 1'b0) $display("FAIL add_release: got resp_valid=%b busy=%b expected 0 0", resp_valid, busy); else passed++;
    endtask

    task automatic test_contention();
        int g, rid;
        logic [N-1:0] rv;
        logic [31:0] res;
        logic z, e;
        bit to;
        int exp2[3] = '{0, 2, 0};
        int exp4[5] = '{0, 1, 2, 3, 0};
        do_reset();
        pa[0] = 32'd9; pb[0] = 32'd9; pop[0] = 4'd1;
        pa[2] = 32'd9; pb[2] = 32'd9; pop[2] = 4'd1;
        apply();
        req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            capture_op(g, rid, rv, res, z, e, to);
            checks++; if (to) $display("FAIL contention_timeout[%0d]: no response", k); else passed++;
            checks++; if (g !== exp2[k] || rid !== exp2[k]) $display("FAIL contention_grant[%0d]: got grant %0d id %0d expected %0d", k, g, rid, exp2[k]); else passed++;
            checks++; if (res !== 32'd0 || z !== 1'b1) $display("FAIL contention_result[%0d]: got %h z=%b expected 0 1", k, res, z); else passed++;
        end
        do_reset();
        for (int i = 0; i < N; i++) begin pa[i] = $urandom; pb[i] = $urandom; pop[i] = 4'd0; end
        apply();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            capture_op(g, rid, rv, res, z, e, to);
            checks++; if (g !== exp4[k] || rv !== (4'b0001 << exp4[k])) $display("FAIL rotate_grant[%0d]: got grant %0d resp_valid %b expected %0d", k, g, rv, exp4[k]); else passed++;
            checks++; if (res !== pa[exp4[k]] + pb[exp4[k]]) $display("FAIL rotate_result[%0d]: got %h expected %h", k, res, pa[exp4[k]] + pb[exp4[k]]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        pa[0] = 32'd6; pb[0] = 32'd7; pop[0] = 4'd2;
        pa[3] = 32'd1; pb[3] = 32'd2; pop[3] = 4'd0;
        apply();
        resp_ready = 4'b1110;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL bp_first_ready: got %b expected 0001", req_ready); else passed++;
        tick();
        req_valid = 4'b1000;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (resp_valid !== 4'b0001 || resp_result !== 32'd42 || busy !== 1'b1) $display("FAIL bp_stall[%0d]: got resp_valid=%b result=%0d busy=%b expected 0001 42 1", k, resp_valid, resp_result, busy); else passed++;
            checks++; if (req_ready !== '0) $display("FAIL bp_stall_ready[%0d]: got %b expected 0", k, req_ready); else passed++;
            tick();
        end
        resp_ready = '1;
        tick();
        checks++; if (resp_valid !== '0 || busy !== 1'b0) $display("FAIL bp_release: got resp_valid=%b busy=%b expected 0 0", resp_valid, busy); else passed++;
        checks++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b expected 1000", req_ready); else passed++;
        tick();
        req_valid = '0;
        tick();
        checks++; if (resp_valid !== 4'b1000 || resp_result !== 32'd3 || resp_id !== 2'd3) $display("FAIL bp_req3: got resp_valid=%b result=%0d id=%0d expected 1000 3 3", resp_valid, resp_result, resp_id); else passed++;
        tick();
    endtask

    task automatic test_float();
        int g, rid;
        logic [N-1:0] rv;
        logic [31:0] res;
        logic z, e;
        bit to;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            pa[2] = fl_a[k]; pb[2] = fl_b[k]; pop[2] = fl_op[k];
            apply();
            req_valid = 4'b0100;
            capture_op(g, rid, rv, res, z, e, to);
            checks++; if (to || res !== fl_exp[k] || z !== (fl_exp[k] == 32'd0) || e !== 1'b0) $display("FAIL float[%0d]: got %h z=%b e=%b timeout=%0d expected %h", k, res, z, e, to, fl_exp[k]); else passed++;
        end
        req_valid = '0;
    endtask

    task automatic test_illegal();
        int g, rid;
        logic [N-1:0] rv;
        logic [31:0] res;
        logic z, e;
        bit to;
        do_reset();
        pa[1] = 32'd123; pb[1] = 32'd456; pop[1] = 4'hC;
        apply();
        req_valid = 4'b0010;
        capture_op(g, rid, rv, res, z, e, to);
        checks++; if (to || res !== 32'd0 || z !== 1'b1 || e !== 1'b1) $display("FAIL illegal_op: got %h z=%b e=%b expected 0 1 1", res, z, e); else passed++;
        pa[1] = 32'd1; pb[1] = 32'd1; pop[1] = 4'd0;
        apply();
        capture_op(g, rid, rv, res, z, e, to);
        checks++; if (to || res !== 32'd2 || z !== 1'b0 || e !== 1'b0) $display("FAIL illegal_follow: got %h z=%b e=%b expected 2 0 0", res, z, e); else passed++;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        pa[1] = 32'd3; pb[1] = 32'd4; pop[1] = 4'd0;
        apply();
        resp_ready = '0;
        req_valid = 4'b0010;
        n = 0;
        while (resp_valid == '0 && n < 20) begin tick(); n++; end
        checks++; if (resp_valid !== 4'b0010) $display("FAIL midrst_reach_resp: got %b expected 0010", resp_valid); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (resp_valid !== '0 || busy !== 1'b0 || resp_result !== 32'd0) $display("FAIL midrst_async: got resp_valid=%b busy=%b result=%0d expected 0 0 0", resp_valid, busy, resp_result); else passed++;
        tick();
        rst = 1'b0;
        req_valid = '0;
        resp_ready = '1;
        tick();
        tick();
        checks++; if (resp_valid !== '0 || busy !== 1'b0) $display("FAIL midrst_no_resp: got resp_valid=%b busy=%b expected 0 0", resp_valid, busy); else passed++;
        req_valid = '1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL midrst_next_grant: got %b expected 0001", req_ready); else passed++;
        req_valid = '0;
    endtask

    task automatic test_random();
        int g, rid, exp_g;
        logic [N-1:0] rv;
        logic [31:0] res, exp_res;
        logic z, e;
        bit to;
        do_reset();
        for (int i = 0; i < N; i++) begin pa[i] = $urandom; pb[i] = $urandom; pop[i] = rand_op(); end
        apply();
        req_valid = 4'($urandom_range(1, 15));
        for (int k = 0; k < 40; k++) begin
            exp_g = rr_pick(req_valid, last_model);
            exp_res = ref_int(pop[exp_g], pa[exp_g], pb[exp_g]);
            capture_op(g, rid, rv, res, z, e, to);
            checks++; if (to || g !== exp_g || rid !== exp_g) $display("FAIL random_grant[%0d]: got grant %0d id %0d expected %0d", k, g, rid, exp_g); else passed++;
            checks++; if (res !== exp_res || z !== (exp_res == 32'd0) || e !== (pop[exp_g] > 4'd9)) $display("FAIL random_result[%0d]: op %0d got %h z=%b e=%b expected %h", k, pop[exp_g], res, z, e, exp_res); else passed++;
            last_model = exp_g;
            pa[exp_g] = $urandom; pb[exp_g] = $urandom; pop[exp_g] = rand_op();
            apply();
            req_valid[exp_g] = 1'($urandom_range(0, 1));
            if (req_valid == '0) req_valid[exp_g] = 1'b1;
        end
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '1;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_float();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
